// File: rtl/rf80386_bus_arbiter.sv
// Round-robin arbiter merging the icache refill port and the data port onto one
// tagged bus master; one transaction outstanding, with retry back-off and a response timeout.
module rf80386_bus_arbiter #(
    parameter logic [5:0]  CORENO   = 6'd1,
    parameter logic [2:0]  CID      = 3'd1,
    parameter int unsigned RTY_WAIT = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic         clk_i,
    input  logic         rst_ni,

    // Instruction (refill) port
    input  logic         ireq_i,
    input  logic [31:0]  iadr_i,
    output logic         iack_o,
    output logic         ierr_o,
    output logic [127:0] idat_o,

    // Data port
    input  logic         dreq_i,
    input  logic         dwe_i,
    input  logic [31:0]  dadr_i,
    input  logic [15:0]  dsel_i,
    input  logic [127:0] ddat_i,
    output logic         dack_o,
    output logic         derr_o,
    output logic [127:0] ddat_o,

    // Bus master
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [31:0]  adr_o,
    output logic [15:0]  sel_o,
    output logic [127:0] dat_o,
    output logic [5:0]   tid_core_o,
    output logic [2:0]   tid_chan_o,
    output logic [3:0]   tid_tran_o,

    // Bus response
    input  logic         ack_i,
    input  logic         rty_i,
    input  logic [3:0]   tid_tran_i,
    input  logic [127:0] dat_i
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRetry
    } state_e;

    // Counter values at which the timeout / retry back-off expire on the next edge
    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);
    localparam logic [15:0] RtyLast = 16'(RTY_WAIT - 1);

    state_e         state_q, state_d;
    logic [3:0]     tid_q, tid_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           last_instr_q, last_instr_d;
    logic           gnt_instr_q, gnt_instr_d;
    logic           we_q, we_d;
    logic [31:0]    adr_q, adr_d;
    logic [15:0]    sel_q, sel_d;
    logic [127:0]   wdat_q, wdat_d;
    logic           iack_q, iack_d;
    logic           ierr_q, ierr_d;
    logic           dack_q, dack_d;
    logic           derr_q, derr_d;
    logic [127:0]   idat_q, idat_d;
    logic [127:0]   ddat_q, ddat_d;

    logic           grant_instr;
    logic           rsp_match;

    // Tid sequence 1..15 then back to 1; 0 is reserved for "nothing issued"
    function automatic logic [3:0] next_tid(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    // On contention the port not served last wins
    assign grant_instr = ireq_i && (!dreq_i || !last_instr_q);
    assign rsp_match   = (tid_tran_i == tid_q);

    always_comb begin
        state_d      = state_q;
        tid_d        = tid_q;
        cnt_d        = cnt_q;
        last_instr_d = last_instr_q;
        gnt_instr_d  = gnt_instr_q;
        we_d         = we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        wdat_d       = wdat_q;
        iack_d       = 1'b0;
        ierr_d       = 1'b0;
        dack_d       = 1'b0;
        derr_d       = 1'b0;
        idat_d       = idat_q;
        ddat_d       = ddat_q;

        case (state_q)
            StIdle: begin
                if (ireq_i || dreq_i) begin
                    gnt_instr_d  = grant_instr;
                    last_instr_d = grant_instr;
                    tid_d        = next_tid(tid_q);
                    cnt_d        = '0;
                    state_d      = StIssue;
                    if (grant_instr) begin
                        adr_d  = iadr_i;
                        we_d   = 1'b0;
                        sel_d  = 16'hFFFF;
                        wdat_d = '0;
                    end else begin
                        adr_d  = dadr_i;
                        we_d   = dwe_i;
                        sel_d  = dsel_i;
                        wdat_d = ddat_i;
                    end
                end
            end

            StIssue: begin
                // The counter runs from the strobe cycle, so it reads k in the k-th cycle after stb
                cnt_d   = cnt_q + 16'd1;
                state_d = StWait;
            end

            StWait: begin
                if (ack_i && rsp_match) begin
                    state_d = StIdle;
                    if (gnt_instr_q) begin
                        iack_d = 1'b1;
                        idat_d = dat_i;
                    end else begin
                        dack_d = 1'b1;
                        ddat_d = dat_i;
                    end
                end else if (rty_i && rsp_match) begin
                    cnt_d   = '0;
                    state_d = StRetry;
                end else if (cnt_q == TmoLast) begin
                    state_d = StIdle;
                    if (gnt_instr_q) begin
                        ierr_d = 1'b1;
                        idat_d = '0;
                    end else begin
                        derr_d = 1'b1;
                        ddat_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StRetry: begin
                if (cnt_q == RtyLast) begin
                    tid_d   = next_tid(tid_q);
                    cnt_d   = '0;
                    state_d = StIssue;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            tid_q        <= '0;
            cnt_q        <= '0;
            last_instr_q <= 1'b1;
            gnt_instr_q  <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            wdat_q       <= '0;
            iack_q       <= 1'b0;
            ierr_q       <= 1'b0;
            dack_q       <= 1'b0;
            derr_q       <= 1'b0;
            idat_q       <= '0;
            ddat_q       <= '0;
        end else begin
            state_q      <= state_d;
            tid_q        <= tid_d;
            cnt_q        <= cnt_d;
            last_instr_q <= last_instr_d;
            gnt_instr_q  <= gnt_instr_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            wdat_q       <= wdat_d;
            iack_q       <= iack_d;
            ierr_q       <= ierr_d;
            dack_q       <= dack_d;
            derr_q       <= derr_d;
            idat_q       <= idat_d;
            ddat_q       <= ddat_d;
        end
    end

    assign cyc_o      = (state_q == StIssue) || (state_q == StWait);
    assign stb_o      = (state_q == StIssue);
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign sel_o      = sel_q;
    assign dat_o      = wdat_q;
    assign tid_core_o = CORENO;
    assign tid_chan_o = CID;
    assign tid_tran_o = tid_q;

    assign iack_o = iack_q;
    assign ierr_o = ierr_q;
    assign idat_o = idat_q;
    assign dack_o = dack_q;
    assign derr_o = derr_q;
    assign ddat_o = ddat_q;

endmodule

// File: tb/tb_rf80386_bus_arbiter.sv
// Directed bench for rf80386_bus_arbiter: reset, reads/writes, contention, retry, timeout,
// tid wrap with a stale response, and reset during an outstanding cycle.
module tb_rf80386_bus_arbiter;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         ireq_i, dreq_i, dwe_i, ack_i, rty_i;
    logic [31:0]  iadr_i, dadr_i;
    logic [15:0]  dsel_i;
    logic [127:0] ddat_i, dat_i;
    logic [3:0]   tid_tran_i;
    logic         iack_o, ierr_o, dack_o, derr_o;
    logic [127:0] idat_o, ddat_o, dat_o;
    logic         cyc_o, stb_o, we_o;
    logic [31:0]  adr_o;
    logic [15:0]  sel_o;
    logic [5:0]   tid_core_o;
    logic [2:0]   tid_chan_o;
    logic [3:0]   tid_tran_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf80386_bus_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ireq_i     (ireq_i),
        .iadr_i     (iadr_i),
        .iack_o     (iack_o),
        .ierr_o     (ierr_o),
        .idat_o     (idat_o),
        .dreq_i     (dreq_i),
        .dwe_i      (dwe_i),
        .dadr_i     (dadr_i),
        .dsel_i     (dsel_i),
        .ddat_i     (ddat_i),
        .dack_o     (dack_o),
        .derr_o     (derr_o),
        .ddat_o     (ddat_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .adr_o      (adr_o),
        .sel_o      (sel_o),
        .dat_o      (dat_o),
        .tid_core_o (tid_core_o),
        .tid_chan_o (tid_chan_o),
        .tid_tran_o (tid_tran_o),
        .ack_i      (ack_i),
        .rty_i      (rty_i),
        .tid_tran_i (tid_tran_i),
        .dat_i      (dat_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ireq_i = 0; iadr_i = '0; dreq_i = 0; dwe_i = 0; dadr_i = '0; dsel_i = '0;
        ddat_i = '0; ack_i = 0; rty_i = 0; tid_tran_i = '0; dat_i = '0;
    endtask

    task automatic apply_reset;
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Advance until stb_o is seen, at most limit cycles
    task automatic wait_stb(input int limit, output int cycles, output bit found);
        found = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            if (stb_o === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    // Drive one response cycle; returns in the cycle where registered results are visible
    task automatic respond(input bit a, input bit r, input logic [3:0] t, input logic [127:0] d);
        ack_i = a; rty_i = r; tid_tran_i = t; dat_i = d;
        tick();
        ack_i = 0; rty_i = 0; tid_tran_i = '0; dat_i = '0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        clear_inputs();
        dreq_i = 1; ireq_i = 1; dadr_i = 32'h1234_5678; ack_i = 1; dat_i = {4{32'hFFFF_FFFF}};
        repeat (2) tick();
        n_cmp++;
        if ({cyc_o, stb_o, we_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl: got %b, want 000", {cyc_o, stb_o, we_o});
        end
        n_cmp++;
        if (sel_o !== 16'h0 || adr_o !== 32'h0 || dat_o !== 128'h0) begin
            n_err++; $display("FAIL reset_fields: sel %h adr %h dat %h, want all 0", sel_o, adr_o, dat_o);
        end
        n_cmp++;
        if (tid_tran_o !== 4'd0) begin
            n_err++; $display("FAIL reset_tid: got %0d, want 0", tid_tran_o);
        end
        n_cmp++;
        if ({iack_o, ierr_o, dack_o, derr_o} !== 4'b0000) begin
            n_err++; $display("FAIL reset_pulses: got %b, want 0000", {iack_o, ierr_o, dack_o, derr_o});
        end
        n_cmp++;
        if (idat_o !== 128'h0 || ddat_o !== 128'h0) begin
            n_err++; $display("FAIL reset_data: idat %h ddat %h, want 0", idat_o, ddat_o);
        end
        n_cmp++;
        if (tid_core_o !== 6'd1 || tid_chan_o !== 3'd1) begin
            n_err++; $display("FAIL tid_const: core %0d chan %0d, want 1 1", tid_core_o, tid_chan_o);
        end
        clear_inputs();
    endtask

    task automatic test_single_read;
        apply_reset();
        dreq_i = 1; dwe_i = 0; dadr_i = 32'h1000; dsel_i = 16'hFFFF;
        tick();
        n_cmp++;
        if ({cyc_o, stb_o} !== 2'b11) begin
            n_err++; $display("FAIL rd_issue: cyc/stb %b, want 11", {cyc_o, stb_o});
        end
        n_cmp++;
        if (adr_o !== 32'h1000 || we_o !== 1'b0 || tid_tran_o !== 4'd1) begin
            n_err++; $display("FAIL rd_fields: adr %h we %b tid %0d, want 1000 0 1", adr_o, we_o, tid_tran_o);
        end
        dreq_i = 0;
        tick();
        n_cmp++;
        if ({cyc_o, stb_o} !== 2'b10) begin
            n_err++; $display("FAIL rd_wait: cyc/stb %b, want 10", {cyc_o, stb_o});
        end
        tick();
        respond(1, 0, 4'd1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        n_cmp++;
        if (dack_o !== 1'b1 || iack_o !== 1'b0 || cyc_o !== 1'b0) begin
            n_err++; $display("FAIL rd_ack: dack %b iack %b cyc %b, want 1 0 0", dack_o, iack_o, cyc_o);
        end
        n_cmp++;
        if (ddat_o !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA) begin
            n_err++; $display("FAIL rd_data: got %h, want deadbeef0123456789abcdef5555aaaa", ddat_o);
        end
        tick();
        n_cmp++;
        if (dack_o !== 1'b0 || cyc_o !== 1'b0) begin
            n_err++; $display("FAIL rd_one_pulse: dack %b cyc %b, want 0 0", dack_o, cyc_o);
        end
    endtask

    task automatic test_write_min_latency;
        apply_reset();
        dreq_i = 1; dwe_i = 1; dadr_i = 32'h0000_2468; dsel_i = 16'h00F0;
        ddat_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        tick();
        n_cmp++;
        if (we_o !== 1'b1 || sel_o !== 16'h00F0 || dat_o !== 128'h1111_2222_3333_4444_5555_6666_7777_8888) begin
            n_err++; $display("FAIL wr_fields: we %b sel %h dat %h, want 1 00f0 1111..8888", we_o, sel_o, dat_o);
        end
        dreq_i = 0; dwe_i = 0;
        tick();
        respond(1, 0, 4'd1, 128'h0);
        n_cmp++;
        if (dack_o !== 1'b1) begin
            n_err++; $display("FAIL wr_latency3: dack %b three cycles after request, want 1", dack_o);
        end
    endtask

    task automatic test_contention;
        int cyc_cnt;
        bit found;
        bit exp_i;
        apply_reset();
        ireq_i = 1; iadr_i = 32'h2000; dreq_i = 1; dadr_i = 32'h3000; dsel_i = 16'h00FF; dwe_i = 0;
        for (int k = 0; k < 3; k++) begin
            exp_i = (k == 1);
            wait_stb(10, cyc_cnt, found);
            n_cmp++;
            if (!found || cyc_cnt != 1) begin
                n_err++; $display("FAIL cont_stb%0d: found %b after %0d cycles, want 1 after 1", k, found, cyc_cnt);
            end
            n_cmp++;
            if (adr_o !== (exp_i ? 32'h2000 : 32'h3000) || tid_tran_o !== 4'(k + 1)
                || sel_o !== (exp_i ? 16'hFFFF : 16'h00FF)) begin
                n_err++; $display("FAIL cont_grant%0d: adr %h tid %0d sel %h, want port %s tid %0d",
                                  k, adr_o, tid_tran_o, sel_o, exp_i ? "instr" : "data", k + 1);
            end
            tick();
            respond(1, 0, 4'(k + 1), {96'h0, 32'hA000 + 32'(k)});
            n_cmp++;
            if ({iack_o, dack_o} !== (exp_i ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL cont_ack%0d: iack/dack %b, want %b", k, {iack_o, dack_o},
                                  exp_i ? 2'b10 : 2'b01);
            end
            if (exp_i) begin
                n_cmp++;
                if (idat_o !== {96'h0, 32'hA001}) begin
                    n_err++; $display("FAIL cont_idat: got %h, want a001", idat_o);
                end
            end
            if (k == 2) begin
                ireq_i = 0; dreq_i = 0;
            end
        end
    endtask

    task automatic test_retry;
        int cyc_cnt;
        int low;
        int pulses;
        bit found;
        apply_reset();
        dreq_i = 1; dadr_i = 32'h4000; dsel_i = 16'hFFFF;
        wait_stb(10, cyc_cnt, found);
        n_cmp++;
        if (!found || tid_tran_o !== 4'd1) begin
            n_err++; $display("FAIL rty_first: found %b tid %0d, want 1 1", found, tid_tran_o);
        end
        dreq_i = 0;
        tick();
        respond(0, 1, 4'd1, 128'h0);
        low = 0;
        for (int i = 0; i < 100; i++) begin
            if (cyc_o === 1'b1) break;
            low++;
            tick();
        end
        n_cmp++;
        if (low != 16) begin
            n_err++; $display("FAIL rty_gap: cyc_o low %0d cycles, want 16", low);
        end
        n_cmp++;
        if (stb_o !== 1'b1 || tid_tran_o !== 4'd2 || adr_o !== 32'h4000) begin
            n_err++; $display("FAIL rty_reissue: stb %b tid %0d adr %h, want 1 2 4000", stb_o, tid_tran_o, adr_o);
        end
        tick();
        respond(1, 0, 4'd2, 128'h77);
        pulses = (dack_o === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dack_o === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || ddat_o !== 128'h77) begin
            n_err++; $display("FAIL rty_ack: %0d dack pulses ddat %h, want 1 pulse 77", pulses, ddat_o);
        end
    endtask

    task automatic test_ack_rty_precedence;
        int cyc_cnt;
        int busy;
        bit found;
        apply_reset();
        dreq_i = 1; dadr_i = 32'h4400;
        wait_stb(10, cyc_cnt, found);
        dreq_i = 0;
        tick();
        respond(1, 1, 4'd1, 128'h99);
        n_cmp++;
        if (dack_o !== 1'b1 || cyc_o !== 1'b0) begin
            n_err++; $display("FAIL prec_ack: dack %b cyc %b, want 1 0", dack_o, cyc_o);
        end
        busy = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cyc_o === 1'b1) busy++;
        end
        n_cmp++;
        if (busy != 0) begin
            n_err++; $display("FAIL prec_noretry: cyc_o high %0d cycles, want 0", busy);
        end
    endtask

    task automatic test_timeout;
        int cyc_cnt;
        int n;
        bit found;
        apply_reset();
        dreq_i = 1; dadr_i = 32'h5000;
        wait_stb(10, cyc_cnt, found);
        dreq_i = 0;
        tick();
        respond(1, 0, 4'd1, 128'hCAFE);
        dreq_i = 1;
        wait_stb(10, cyc_cnt, found);
        n_cmp++;
        if (!found || tid_tran_o !== 4'd2) begin
            n_err++; $display("FAIL tmo_issue: found %b tid %0d, want 1 2", found, tid_tran_o);
        end
        dreq_i = 0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (derr_o === 1'b1) break;
        end
        n_cmp++;
        if (derr_o !== 1'b1 || n != 255) begin
            n_err++; $display("FAIL tmo_time: derr %b after %0d cycles, want 1 after 255", derr_o, n);
        end
        n_cmp++;
        if (ddat_o !== 128'h0 || cyc_o !== 1'b0 || dack_o !== 1'b0) begin
            n_err++; $display("FAIL tmo_state: ddat %h cyc %b dack %b, want 0 0 0", ddat_o, cyc_o, dack_o);
        end
        tick();
        n_cmp++;
        if (derr_o !== 1'b0 || cyc_o !== 1'b0) begin
            n_err++; $display("FAIL tmo_idle: derr %b cyc %b, want 0 0", derr_o, cyc_o);
        end
    endtask

    task automatic test_tid_wrap;
        int cyc_cnt;
        bit found;
        logic [3:0] exp_tid;
        apply_reset();
        dreq_i = 1; dadr_i = 32'h6000;
        for (int k = 0; k < 16; k++) begin
            exp_tid = (k == 15) ? 4'd1 : 4'(k + 1);
            wait_stb(10, cyc_cnt, found);
            n_cmp++;
            if (!found || tid_tran_o !== exp_tid) begin
                n_err++; $display("FAIL wrap_tid%0d: found %b tid %0d, want %0d", k, found, tid_tran_o, exp_tid);
            end
            tick();
            if (k == 2) begin
                respond(1, 0, 4'd7, 128'hBAD);
                n_cmp++;
                if (dack_o !== 1'b0 || cyc_o !== 1'b1) begin
                    n_err++; $display("FAIL stale_ack: dack %b cyc %b, want 0 1", dack_o, cyc_o);
                end
            end
            if (k == 15) dreq_i = 0;
            respond(1, 0, exp_tid, 128'(k));
            n_cmp++;
            if (dack_o !== 1'b1 || ddat_o !== 128'(k)) begin
                n_err++; $display("FAIL wrap_ack%0d: dack %b ddat %h, want 1 %h", k, dack_o, ddat_o, k);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        int cyc_cnt;
        int pulses;
        bit found;
        apply_reset();
        dreq_i = 1; dadr_i = 32'h7000;
        wait_stb(10, cyc_cnt, found);
        dreq_i = 0;
        tick();
        n_cmp++;
        if (cyc_o !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: cyc %b in WAIT, want 1", cyc_o);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (cyc_o !== 1'b0 || tid_tran_o !== 4'd0) begin
            n_err++; $display("FAIL mid_async: cyc %b tid %0d, want 0 0", cyc_o, tid_tran_o);
        end
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if ({iack_o, ierr_o, dack_o, derr_o} !== 4'b0000) pulses++;
        end
        rst_ni = 1'b1;
        respond(1, 0, 4'd1, 128'h5A);
        for (int i = 0; i < 3; i++) begin
            if ({iack_o, ierr_o, dack_o, derr_o} !== 4'b0000) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0 || cyc_o !== 1'b0) begin
            n_err++; $display("FAIL mid_nopulse: %0d pulse cycles cyc %b, want 0 0", pulses, cyc_o);
        end
        dreq_i = 1;
        wait_stb(10, cyc_cnt, found);
        dreq_i = 0;
        n_cmp++;
        if (!found || tid_tran_o !== 4'd1) begin
            n_err++; $display("FAIL mid_newtid: found %b tid %0d, want 1 1", found, tid_tran_o);
        end
        tick();
        respond(1, 0, 4'd1, 128'h0);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_min_latency();
        test_contention();
        test_retry();
        test_ack_rty_precedence();
        test_timeout();
        test_tid_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rf80386_bus_arbiter.md
RF80386_BUS_ARBITER -- requirements
Module: rf80386_bus_arbiter

Interface
REQ-001 SHALL have parameter CORENO, default 6'd1, core number driven on tid_core_o.
REQ-002 SHALL have parameter CID, default 3'd1, channel number driven on tid_chan_o.
REQ-003 SHALL have parameter RTY_WAIT, default 16, idle cycles between a retry response and reissue.
REQ-004 SHALL have parameter TIMEOUT, default 255, cycles without a matching response before abort.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset, with ports:
- clk_i  in  1  clock, all flops on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have the instruction-port signals:
- ireq_i  in  1  icache refill request, level.
- iadr_i  in  32  refill address, 16-byte aligned.
- iack_o  out  1  one-cycle refill completion.
- ierr_o  out  1  one-cycle refill abort.
- idat_o  out  128  refill line.
REQ-007 SHALL have the data-port signals:
- dreq_i  in  1  data request, level.
- dwe_i  in  1  write when 1.
- dadr_i  in  32  data address.
- dsel_i  in  16  byte lanes.
- ddat_i  in  128  write data.
- dack_o  out  1  one-cycle completion.
- derr_o  out  1  one-cycle abort.
- ddat_o  out  128  read data.
REQ-008 SHALL have the bus-master signals:
- cyc_o  out  1  cycle.
- stb_o  out  1  strobe.
- we_o  out  1  write enable.
- adr_o  out  32  address.
- sel_o  out  16  byte select.
- dat_o  out  128  write data.
- tid_core_o  out  6  transaction core field.
- tid_chan_o  out  3  transaction channel field.
- tid_tran_o  out  4  transaction number.
REQ-009 SHALL have the bus-response signals:
- ack_i  in  1  acknowledge.
- rty_i  in  1  retry.
- tid_tran_i  in  4  response transaction number.
- dat_i  in  128  read data.

Function
REQ-010 SHALL implement the states IDLE, ISSUE, WAIT, RETRY.
REQ-011 IDLE: when ireq_i or dreq_i is high, SHALL latch the winner's address, sel, we and data, advance tid, and enter ISSUE on the next cycle.
REQ-012 Arbitration SHALL be round-robin; on simultaneous requests the port not served last wins; after reset the data port wins.
REQ-013 An instruction grant SHALL drive we_o=0 and sel_o=16'hFFFF.
REQ-014 ISSUE SHALL assert cyc_o and stb_o for exactly one cycle with the latched fields, then enter WAIT.
REQ-015 WAIT SHALL hold cyc_o=1 and stb_o=0, and SHALL increment a timeout counter each cycle.
REQ-016 In WAIT, ack_i with tid_tran_i equal to the current tid SHALL:
- pulse the granted port's ack for one cycle;
- present dat_i on that port's data output in the same cycle;
- drop cyc_o;
- return to IDLE.
REQ-017 A response whose tid_tran_i does not match SHALL be ignored.
REQ-018 In WAIT, rty_i with a matching tid SHALL drop cyc_o and enter RETRY.
REQ-019 RETRY SHALL count RTY_WAIT cycles, then allocate a new tid and re-enter ISSUE with unchanged latched fields.
REQ-020 When the timeout counter reaches TIMEOUT in WAIT, SHALL pulse the granted port's err for one cycle, drive that port's data output to 0, drop cyc_o, and return to IDLE.
REQ-021 The timeout counter SHALL clear on every entry to ISSUE.
REQ-022 The tid SHALL advance 1..15 and wrap 15->1; the value 0 SHALL never be issued.
REQ-023 A request deasserted while its grant is in flight SHALL NOT abort the bus cycle; completion is still pulsed.
REQ-024 ack_i and rty_i asserted in the same cycle with a matching tid: ack SHALL take precedence.
REQ-025 At most one transaction SHALL be outstanding; the losing request waits in IDLE arbitration.
REQ-026 The minimum latency SHALL be 3 cycles, request-high to ack pulse, given a bus ack in the first WAIT cycle.
REQ-027 tid_core_o and tid_chan_o SHALL be driven constantly from CORENO and CID.

Reset
REQ-028 While rst_ni=0, outputs SHALL be:
- cyc_o, stb_o, we_o = 0;
- sel_o = 0, adr_o = 0, dat_o = 0;
- tid_tran_o = 0;
- all ack and err outputs = 0;
- all data outputs = 0.
REQ-029 While rst_ni=0, the internal tid SHALL be 0, so the first issued tid is 1; the state SHALL be IDLE and the last-served port SHALL be instruction.
REQ-030 Reset asserted mid-transaction SHALL abandon it with no ack or err pulse; late responses after reset SHALL be ignored via tid mismatch.

Verification
REQ-031 Single read: dreq_i=1, dadr_i=32'h1000, bus ack with tid 1 two cycles after stb -> dack_o pulses once, ddat_o=dat_i, cyc_o low next cycle.
REQ-032 Contention: ireq_i and dreq_i high together from reset -> data served (tid 1), then instruction (tid 2), then data (tid 3).
REQ-033 Retry: rty_i with tid 1 -> cyc_o low for 16 cycles, reissue with tid 2, ack tid 2 -> single dack_o.
REQ-034 Timeout: no response -> derr_o pulses 255 cycles after stb, ddat_o=0, state IDLE.
REQ-035 Tid wrap and stale response: 16 back-to-back transactions -> tids 1..15, 1; an ack with stale tid 7 during WAIT -> ignored.
REQ-036 Reset mid-WAIT: rst_ni low 2 cycles -> cyc_o=0 immediately, no ack/err pulse, next tid is 1.
